// File: rtl/time_set_controller.sv
`default_nettype none
//----------------------------------------------------------------------------
// time_set_controller : debounced hour/minute set sequencer for the alarm clock
// Rev 1.0
//----------------------------------------------------------------------------
module time_set_controller #(
  parameter int unsigned     DEBOUNCE_CYCLES = 1_000_000,
  parameter longint unsigned TIMEOUT_CYCLES  = 64'd3_000_000_000
) (
  input  logic       CLK100MHZ,
  input  logic       reset,
  input  logic       st_but,
  input  logic       nxt_but,
  input  logic [5:0] in_time,
  input  logic       m,
  output logic       commit,
  output logic       target,
  output logic [4:0] hr_out,
  output logic [5:0] min_out,
  output logic       hold_time,
  output logic       err,
  output logic       timeout,
  output logic [2:0] state_LED
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  // Encodings double as the LED pattern so state_LED comes straight off the flops.
  typedef enum logic [2:0] {
    S_RUN  = 3'b001,
    S_HR   = 3'b010,
    S_MIN  = 3'b011,
    S_CONF = 3'b100
  } state_t;

  state_t          state;
  logic [1:0]      raw;
  logic [1:0]      press;
  logic [TO_W-1:0] idle;
  logic            st_go;
  logic            nxt_go;
  logic            expire;

  assign raw = {nxt_but, st_but};

  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic            sync1;
    logic            sync2;
    logic            level;
    logic            level_d;
    logic            pulse;
    logic [DB_W-1:0] cnt;

    always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset) begin
        sync1   <= 1'b0;
        sync2   <= 1'b0;
        level   <= 1'b0;
        level_d <= 1'b0;
        pulse   <= 1'b0;
        cnt     <= '0;
      end else begin
        sync1 <= raw[i];
        sync2 <= sync1;
        if (sync2 != level) begin
          if (cnt == DB_LAST) begin
            level <= sync2;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else begin
          cnt <= '0;
        end
        level_d <= level;
        pulse   <= level & ~level_d;
      end
    end

    assign press[i] = pulse;
  end

  // Cancel outranks advance when both land in the same cycle.
  assign nxt_go    = press[1];
  assign st_go     = press[0] & ~press[1];
  assign expire    = (idle == TO_LAST);
  assign state_LED = state;

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      state     <= S_RUN;
      target    <= 1'b0;
      hr_out    <= '0;
      min_out   <= '0;
      commit    <= 1'b0;
      err       <= 1'b0;
      timeout   <= 1'b0;
      hold_time <= 1'b0;
      idle      <= '0;
    end else begin
      commit  <= 1'b0;
      err     <= 1'b0;
      timeout <= 1'b0;
      if (state == S_RUN || st_go || nxt_go || expire) idle <= '0;
      else                                             idle <= idle + 1'b1;

      case (state)
        S_RUN: begin
          if (st_go) begin
            state     <= S_HR;
            target    <= m;
            hold_time <= ~m;
          end
        end
        S_HR: begin
          if (nxt_go) begin
            state     <= S_RUN;
            hold_time <= 1'b0;
          end else if (st_go) begin
            if (in_time <= 6'd23) begin
              hr_out <= in_time[4:0];
              state  <= S_MIN;
            end else begin
              err <= 1'b1;
            end
          end else if (expire) begin
            timeout   <= 1'b1;
            state     <= S_RUN;
            hold_time <= 1'b0;
          end
        end
        S_MIN: begin
          if (nxt_go) begin
            state     <= S_RUN;
            hold_time <= 1'b0;
          end else if (st_go) begin
            if (in_time <= 6'd59) begin
              min_out <= in_time;
              state   <= S_CONF;
            end else begin
              err <= 1'b1;
            end
          end else if (expire) begin
            timeout   <= 1'b1;
            state     <= S_RUN;
            hold_time <= 1'b0;
          end
        end
        S_CONF: begin
          if (nxt_go) begin
            state <= S_HR;
          end else if (st_go) begin
            commit    <= 1'b1;
            state     <= S_RUN;
            hold_time <= 1'b0;
          end else if (expire) begin
            timeout   <= 1'b1;
            state     <= S_RUN;
            hold_time <= 1'b0;
          end
        end
        default: begin
          state     <= S_RUN;
          hold_time <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_time_set_controller.sv
`default_nettype none
//----------------------------------------------------------------------------
// tb_time_set_controller : directed + random bench with a cycle-level reference model
// Rev 1.0
//----------------------------------------------------------------------------
module tb_time_set_controller;

  localparam int DB   = 4;
  localparam int TO   = 100;
  localparam int LAT  = 8;   // negedge raw rise -> edge where the FSM reacts
  localparam int RUN  = 1;
  localparam int HR   = 2;
  localparam int MIN  = 3;
  localparam int CONF = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       st_but;
  logic       nxt_but;
  logic [5:0] in_time;
  logic       m;
  logic       commit;
  logic       target;
  logic [4:0] hr_out;
  logic [5:0] min_out;
  logic       hold_time;
  logic       err;
  logic       timeout;
  logic [2:0] state_LED;

  time_set_controller #(
    .DEBOUNCE_CYCLES(DB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLK100MHZ(clk),
    .reset    (reset),
    .st_but   (st_but),
    .nxt_but  (nxt_but),
    .in_time  (in_time),
    .m        (m),
    .commit   (commit),
    .target   (target),
    .hr_out   (hr_out),
    .min_out  (min_out),
    .hold_time(hold_time),
    .err      (err),
    .timeout  (timeout),
    .state_LED(state_LED)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: presses become events at a known latency; FSM rules applied directly.
  int         cyc = 0;
  int         stq[$];
  int         nxq[$];
  int         ms;
  int         idle;
  logic       e_commit, e_err, e_to, e_tgt;
  logic [4:0] e_hr;
  logic [5:0] e_min;
  int         exp_commits = 0;
  int         dut_commits = 0;
  bit         chk_en = 0;

  task automatic model_reset();
    ms = RUN; idle = 0;
    e_commit = 0; e_err = 0; e_to = 0; e_tgt = 0;
    e_hr = '0; e_min = '0;
    stq.delete(); nxq.delete();
  endtask

  task automatic model_step();
    bit se, ne;
    se = 0; ne = 0;
    if (stq.size() > 0 && stq[0] == cyc) begin se = 1; stq.delete(0); end
    if (nxq.size() > 0 && nxq[0] == cyc) begin ne = 1; nxq.delete(0); end
    if (ne) se = 0;
    e_commit = 0; e_err = 0; e_to = 0;
    if (ms == RUN) begin
      idle = 0;
      if (se) begin ms = HR; e_tgt = m; end
    end else if (se || ne) begin
      idle = 0;
      case (ms)
        HR:  if (ne) ms = RUN;
             else if (in_time <= 23) begin e_hr = in_time[4:0]; ms = MIN; end
             else e_err = 1;
        MIN: if (ne) ms = RUN;
             else if (in_time <= 59) begin e_min = in_time; ms = CONF; end
             else e_err = 1;
        default: if (ne) ms = HR;
                 else begin e_commit = 1; exp_commits++; ms = RUN; end
      endcase
    end else begin
      idle++;
      if (idle == TO) begin e_to = 1; ms = RUN; idle = 0; end
    end
  endtask

  function automatic logic [31:0] exp_vec();
    logic [2:0] led;
    led = 3'(ms);
    return {13'd0, led, e_commit, e_err, e_to, e_tgt, (ms != RUN) && !e_tgt, e_hr, e_min};
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!reset) model_step();
  end

  always @(negedge clk) begin
    if (!reset && chk_en) begin
      check("cyc", {13'd0, state_LED, commit, err, timeout, target, hold_time, hr_out, min_out},
            exp_vec());
      if (commit) dut_commits++;
    end
  end

  // Drives one press (or glitch) and schedules the resulting event in the model.
  task automatic press(input bit s, input bit n, input int hold, input int gap);
    @(negedge clk);
    if (hold >= DB) begin
      if (s) stq.push_back(cyc + LAT);
      if (n) nxq.push_back(cyc + LAT);
    end
    st_but  = s;
    nxt_but = n;
    repeat (hold) @(negedge clk);
    st_but  = 1'b0;
    nxt_but = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic st(input logic [5:0] v);
    in_time = v;
    press(1, 0, 6, 8);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; st_but = 1'b0; nxt_but = 1'b0; in_time = '0; m = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    chk_en = 1;
    repeat (3) @(negedge clk);

    // Clock set 15:42
    m = 1'b0;
    st(6'd0); st(6'd15); st(6'd42); st(6'd0);

    // Range checks, then re-edit from CONFIRM and cancel
    st(6'd0); st(6'd24); st(6'd23); st(6'd60); st(6'd59);
    press(0, 1, 6, 8);
    check("reedit_led", state_LED, 3'b010);
    press(0, 1, 6, 8);

    // Bounce: short glitches produce nothing, a 6-cycle hold produces one event
    repeat (3) press(1, 0, 3, 2);
    repeat (8) @(negedge clk);
    check("glitch_led", state_LED, 3'b001);
    press(1, 0, 6, 8);
    check("hold_led", state_LED, 3'b010);

    // Simultaneous buttons in SET_MIN cancel
    st(6'd7);
    in_time = 6'd30;
    press(1, 1, 6, 8);
    check("both_led", state_LED, 3'b001);

    // Alarm with m toggled after entry, then idle timeout
    m = 1'b1;
    st(6'd0);
    m = 1'b0;
    st(6'd5); st(6'd6); st(6'd0);
    m = 1'b1;
    st(6'd0);
    repeat (TO + 10) @(negedge clk);
    check("to_led", state_LED, 3'b001);

    // Asynchronous reset mid-procedure with hold_time high
    m = 1'b0;
    st(6'd0); st(6'd9);
    @(posedge clk);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_led", state_LED, 3'b001);
    check("rst_strb", {commit, err, timeout}, 3'b000);
    check("rst_hold", hold_time, 1'b0);
    check("rst_hr", hr_out, 5'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Random operations
    for (int i = 0; i < 150; i++) begin
      int r;
      m = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       in_time = 6'($urandom_range(0, 23));
        1:       in_time = 6'($urandom_range(0, 59));
        default: in_time = 6'($urandom_range(0, 63));
      endcase
      r = $urandom_range(0, 9);
      if (r <= 4)      press(1, 0, $urandom_range(DB, 10), $urandom_range(6, 12));
      else if (r <= 6) press(0, 1, $urandom_range(DB, 10), $urandom_range(6, 12));
      else if (r == 7) press(1, 1, $urandom_range(DB, 10), $urandom_range(6, 12));
      else if (r == 8) press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                             $urandom_range(1, DB - 1), $urandom_range(6, 12));
      else             repeat ($urandom_range(85, 115)) @(negedge clk);
    end

    repeat (20) @(negedge clk);
    check("ncommit", dut_commits, exp_commits);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
